// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control plane: FSM encoding, button indices, BCD width.
package stopwatch_pkg;

  localparam int unsigned BCD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [1:0] BTN_CLEAR = 2'd0;
  localparam logic [1:0] BTN_RESET = 2'd1;
  localparam logic [1:0] BTN_LAP   = 2'd2;
  localparam logic [1:0] BTN_START = 2'd3;

endpackage

// File: rtl/sw_debounce.sv
// Active-low button debouncer: 2-flop synchronizer, stability counter, one-cycle press pulse.
module sw_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic button_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Accepted level flips after DEB_CYCLES consecutive disagreeing samples; only presses pulse.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= button_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control plane: button debounce, run/pause FSM, BCD lap buffer, LCD refresh handshake.
// Optional display hold after a lap is enabled with `define STOPWATCH_LAP_HOLD_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [3:0]             button_i,
  input  logic [BCD_W-1:0]       time_bcd_i,
  output logic                   count_en_o,
  output logic                   count_clr_o,
  output logic [BCD_W*DEPTH-1:0] lap_flat_o,
  output logic [3:0]             lap_count_o,
  output logic                   lcd_req_o,
  input  logic                   lcd_ack_i,
  output logic                   hold_o
);

  if (DEPTH == 0 || DEPTH > 15 || DEB_CYCLES == 0 || HOLD_CYCLES == 0) begin : g_param_check
    $error("stopwatch_ctrl: parameter out of range");
  end

  logic [3:0] press;
  logic       clear_p;
  logic       reset_p;
  logic       lap_p;
  logic       start_p;
  logic       capture;
  logic       update;
  state_e     state;

  for (genvar b = 0; b < 4; b++) begin : g_deb
    sw_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .button_n(button_i[b]),
      .press   (press[b])
    );
  end

  assign clear_p = press[BTN_CLEAR];
  assign reset_p = press[BTN_RESET];
  assign lap_p   = press[BTN_LAP];
  assign start_p = press[BTN_START];

  // Laps are only taken while timing; a simultaneous clear discards the lap.
  assign capture = lap_p & ~clear_p & (state != ST_IDLE);
  assign update  = capture | clear_p;

  // Run/pause FSM; reset pulse has priority over start/pause.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      count_en_o  <= 1'b0;
      count_clr_o <= 1'b0;
    end else begin
      count_clr_o <= 1'b0;
      if (reset_p) begin
        state       <= ST_IDLE;
        count_en_o  <= 1'b0;
        count_clr_o <= 1'b1;
      end else if (start_p) begin
        case (state)
          ST_IDLE: begin
            state      <= ST_RUN;
            count_en_o <= 1'b1;
          end
          ST_RUN: begin
            state      <= ST_PAUSE;
            count_en_o <= 1'b0;
          end
          ST_PAUSE: begin
            state      <= ST_RUN;
            count_en_o <= 1'b1;
          end
          default: begin
            state      <= ST_IDLE;
            count_en_o <= 1'b0;
          end
        endcase
      end
    end
  end

  // Lap shift buffer (newest in the low word) and coalescing LCD refresh request.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      lap_flat_o  <= '0;
      lap_count_o <= '0;
      lcd_req_o   <= 1'b0;
    end else begin
      if (clear_p) begin
        lap_flat_o  <= '0;
        lap_count_o <= '0;
      end else if (capture) begin
        for (int unsigned k = 1; k < DEPTH; k++) begin
          lap_flat_o[k*BCD_W +: BCD_W] <= lap_flat_o[(k-1)*BCD_W +: BCD_W];
        end
        lap_flat_o[BCD_W-1:0] <= time_bcd_i;
        if (lap_count_o != 4'(DEPTH)) begin
          lap_count_o <= lap_count_o + 4'd1;
        end
      end
      lcd_req_o <= update | (lcd_req_o & ~lcd_ack_i);
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [HOLD_W-1:0] hold_cnt;

  // Freeze window restarts on every running lap; reset or clear cancels it.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hold_o   <= 1'b0;
      hold_cnt <= '0;
    end else if (reset_p || clear_p) begin
      hold_o   <= 1'b0;
      hold_cnt <= '0;
    end else if (capture && state == ST_RUN) begin
      hold_o   <= 1'b1;
      hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
    end else if (hold_o) begin
      if (hold_cnt == '0) begin
        hold_o <= 1'b0;
      end else begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end
`else
  assign hold_o = 1'b0;
`endif

endmodule
